alarm_clock_ctrl: RTL and testbench

Mode sequencer and alarm scheduler for the alarm clock. It turns the two debounced push-keys into set-mode navigation and single-cycle increment pulses for the time and alarm counters, and gates the time counter's run enable. It also compares the running time against the alarm setting and manages the ringing, snooze and timeout behaviour. It sits between the key/switch inputs and the counter datapath, and drives the alarm LED.

---
 rtl/alarm_clock_pkg.sv | 36 +++
 rtl/key_edge.sv | 33 +++
 rtl/alarm_clock_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_alarm_clock_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_clock_pkg.sv
// Shared types and defaults for the alarm clock mode sequencer / alarm scheduler.
//   mode_t      : user-visible mode encoding driven on the `mode` port
//   alm_state_t : alarm scheduler state
//   *_DEF       : default parameter values for alarm_clock_ctrl
package alarm_clock_pkg;

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SET_TH = 3'd1,
    SET_TM = 3'd2,
    SET_AH = 3'd3,
    SET_AM = 3'd4
  } mode_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } alm_state_t;

  localparam int unsigned RING_SEC_DEF   = 60;
  localparam int unsigned SNOOZE_SEC_DEF = 300;
  localparam int unsigned CW_DEF         = 9;

  // Mode key walks RUN -> SET_TH -> SET_TM -> SET_AH -> SET_AM -> RUN.
  function automatic mode_t next_mode(input mode_t m);
    case (m)
      RUN:     return SET_TH;
      SET_TH:  return SET_TM;
      SET_TM:  return SET_AH;
      SET_AH:  return SET_AM;
      default: return RUN;
    endcase
  endfunction

endpackage

// File: rtl/key_edge.sv
// Registered rising-edge detector for one debounced key level.
//   clk_i  : system clock
//   rst_i  : synchronous active-high reset
//   key_i  : debounced key level
//   edge_o : one-cycle pulse, two edges after the key level rises
// Both history registers reset to 1 so a key held through reset is not
// reported as a fresh press.
module key_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic edge_o
);

  logic key_q;
  logic prev_q;
  logic edge_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      key_q  <= 1'b1;
      prev_q <= 1'b1;
      edge_q <= 1'b0;
    end else begin
      key_q  <= key_i;
      prev_q <= key_q;
      edge_q <= key_q & ~prev_q;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/alarm_clock_ctrl.sv
// Mode sequencer and alarm scheduler for the alarm clock.
//   CLK, reset                   : clock, synchronous active-high reset
//   tick_en                      : one-cycle pulse per second
//   key_mode, key_adv            : debounced key levels
//   alarm_arm                    : alarm enable switch
//   hrs/min/sec, hrs_alrm/min_alrm : current time and alarm setting
//   mode                         : current mode (mode_t encoding)
//   time_run                     : time counter run enable
//   inc_th/inc_tm/inc_ah/inc_am  : one-cycle increment pulses
//   sec_clr                      : one-cycle seconds clear pulse
//   ring, snoozing               : alarm status
module alarm_clock_ctrl
  import alarm_clock_pkg::*;
#(
  parameter int unsigned RING_SEC   = RING_SEC_DEF,
  parameter int unsigned SNOOZE_SEC = SNOOZE_SEC_DEF,
  parameter int unsigned CW         = CW_DEF
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       tick_en,
  input  logic       key_mode,
  input  logic       key_adv,
  input  logic       alarm_arm,
  input  logic [7:0] hrs,
  input  logic [7:0] min,
  input  logic [7:0] sec,
  input  logic [7:0] hrs_alrm,
  input  logic [7:0] min_alrm,
  output logic [2:0] mode,
  output logic       time_run,
  output logic       inc_th,
  output logic       inc_tm,
  output logic       inc_ah,
  output logic       inc_am,
  output logic       sec_clr,
  output logic       ring,
  output logic       snoozing
);

  logic mode_edge;
  logic adv_edge;

  key_edge u_mode_edge (
    .clk_i  (CLK),
    .rst_i  (reset),
    .key_i  (key_mode),
    .edge_o (mode_edge)
  );

  key_edge u_adv_edge (
    .clk_i  (CLK),
    .rst_i  (reset),
    .key_i  (key_adv),
    .edge_o (adv_edge)
  );

  mode_t      mode_q, mode_d;
  alm_state_t alm_q, alm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic inc_th_q, inc_th_d;
  logic inc_tm_q, inc_tm_d;
  logic inc_ah_q, inc_ah_d;
  logic inc_am_q, inc_am_d;
  logic sec_clr_q, sec_clr_d;
  logic match_q, match_dly_q;
  logic match;
  logic match_evt;

  // The time compare is registered, and the event is taken from the
  // registered copy, so ring rises two edges after the compare goes true.
  assign match     = (hrs == hrs_alrm) && (min == min_alrm) && (sec == 8'd0);
  assign match_evt = match_q && !match_dly_q && (mode_q == RUN) && alarm_arm;

  always_ff @(posedge CLK) begin
    if (reset) begin
      mode_q      <= RUN;
      alm_q       <= IDLE;
      cnt_q       <= '0;
      inc_th_q    <= 1'b0;
      inc_tm_q    <= 1'b0;
      inc_ah_q    <= 1'b0;
      inc_am_q    <= 1'b0;
      sec_clr_q   <= 1'b0;
      match_q     <= 1'b0;
      match_dly_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      alm_q       <= alm_d;
      cnt_q       <= cnt_d;
      inc_th_q    <= inc_th_d;
      inc_tm_q    <= inc_tm_d;
      inc_ah_q    <= inc_ah_d;
      inc_am_q    <= inc_am_d;
      sec_clr_q   <= sec_clr_d;
      match_q     <= match;
      match_dly_q <= match_q;
    end
  end

  // Mode FSM and increment pulses.
  always_comb begin
    mode_d    = mode_q;
    sec_clr_d = 1'b0;
    inc_th_d  = 1'b0;
    inc_tm_d  = 1'b0;
    inc_ah_d  = 1'b0;
    inc_am_d  = 1'b0;
    // A mode press while ringing only dismisses the alarm.
    if (mode_edge && (alm_q != RINGING)) begin
      mode_d    = next_mode(mode_q);
      sec_clr_d = (mode_q == SET_TM);
    end
    if (adv_edge) begin
      case (mode_q)
        SET_TH:  inc_th_d = 1'b1;
        SET_TM:  inc_tm_d = 1'b1;
        SET_AH:  inc_ah_d = 1'b1;
        SET_AM:  inc_am_d = 1'b1;
        default: ;
      endcase
    end
  end

  // Alarm FSM; one counter serves both ring and snooze intervals.
  always_comb begin
    alm_d = alm_q;
    cnt_d = cnt_q;
    if (!alarm_arm) begin
      alm_d = IDLE;
      cnt_d = '0;
    end else begin
      case (alm_q)
        IDLE: begin
          if (match_evt) begin
            alm_d = RINGING;
            cnt_d = CW'(RING_SEC);
          end
        end
        RINGING: begin
          if (adv_edge && (mode_q == RUN)) begin
            alm_d = SNOOZE;
            cnt_d = CW'(SNOOZE_SEC);
          end else if (mode_edge) begin
            alm_d = IDLE;
            cnt_d = '0;
          end else if (tick_en) begin
            if (cnt_q == CW'(1)) begin
              alm_d = IDLE;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
        end
        SNOOZE: begin
          if (mode_edge) begin
            alm_d = IDLE;
            cnt_d = '0;
          end else if (tick_en) begin
            if (cnt_q == CW'(1)) begin
              alm_d = RINGING;
              cnt_d = CW'(RING_SEC);
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
        end
        default: begin
          alm_d = IDLE;
          cnt_d = '0;
        end
      endcase
    end
  end

  assign mode     = mode_q;
  assign time_run = !((mode_q == SET_TH) || (mode_q == SET_TM));
  assign inc_th   = inc_th_q;
  assign inc_tm   = inc_tm_q;
  assign inc_ah   = inc_ah_q;
  assign inc_am   = inc_am_q;
  assign sec_clr  = sec_clr_q;
  assign ring     = (alm_q == RINGING);
  assign snoozing = (alm_q == SNOOZE);

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
module tb_alarm_clock_ctrl;

  localparam int RING = 60;
  localparam int SNZ  = 300;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       tick_en = 1'b0;
  logic       key_mode = 1'b0;
  logic       key_adv = 1'b0;
  logic       alarm_arm = 1'b0;
  logic [7:0] hrs = '0, min = '0, sec = '0;
  logic [7:0] hrs_alrm = 8'd1, min_alrm = '0;
  logic [2:0] mode;
  logic       time_run, inc_th, inc_tm, inc_ah, inc_am, sec_clr, ring, snoozing;

  int total = 0;
  int bad   = 0;
  int exp_mode = 0;
  int n_th = 0, n_tm = 0, n_ah = 0, n_am = 0, n_clr = 0;

  always #5 CLK = ~CLK;

  alarm_clock_ctrl #(
    .RING_SEC   (RING),
    .SNOOZE_SEC (SNZ),
    .CW         (9)
  ) dut (
    .CLK       (CLK),
    .reset     (reset),
    .tick_en   (tick_en),
    .key_mode  (key_mode),
    .key_adv   (key_adv),
    .alarm_arm (alarm_arm),
    .hrs       (hrs),
    .min       (min),
    .sec       (sec),
    .hrs_alrm  (hrs_alrm),
    .min_alrm  (min_alrm),
    .mode      (mode),
    .time_run  (time_run),
    .inc_th    (inc_th),
    .inc_tm    (inc_tm),
    .inc_ah    (inc_ah),
    .inc_am    (inc_am),
    .sec_clr   (sec_clr),
    .ring      (ring),
    .snoozing  (snoozing)
  );

  // Count high cycles of each pulse output: one press must give exactly one.
  always @(negedge CLK) begin
    n_th  += int'(inc_th);
    n_tm  += int'(inc_tm);
    n_ah  += int'(inc_ah);
    n_am  += int'(inc_am);
    n_clr += int'(sec_clr);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic press_mode();
    key_mode = 1'b1;
    cyc($urandom_range(1, 6));
    key_mode = 1'b0;
    cyc(4);
  endtask

  task automatic press_adv();
    key_adv = 1'b1;
    cyc($urandom_range(1, 6));
    key_adv = 1'b0;
    cyc(4);
  endtask

  // Only used while no alarm is ringing, so every press advances the mode.
  task automatic goto_mode(input int target);
    for (int k = 0; k < 5 && exp_mode != target; k++) begin
      press_mode();
      exp_mode = (exp_mode + 1) % 5;
    end
  endtask

  task automatic do_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      tick_en = 1'b1;
      cyc(1);
      tick_en = 1'b0;
      cyc($urandom_range(1, 2));
    end
  endtask

  // Time steps from hh:(mm-1):59 to hh:mm:00 with the alarm at hh:mm.
  task automatic trigger_ring(input string tag);
    int hh, mm;
    hh = $urandom_range(0, 23);
    mm = $urandom_range(1, 59);
    hrs_alrm = 8'(hh);
    min_alrm = 8'(mm);
    hrs = 8'(hh);
    min = 8'(mm - 1);
    sec = 8'd59;
    cyc(4);
    min = 8'(mm);
    sec = 8'd0;
    cyc(1);
    total++;
    if (ring !== 1'b0) begin
      bad++;
      $display("FAIL %s_ring_early: got %b want 0", tag, ring);
    end
    cyc(1);
    total++;
    if (ring !== 1'b1) begin
      bad++;
      $display("FAIL %s_ring_start: got %b want 1", tag, ring);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    key_mode = 1'b1;
    key_adv = 1'b1;
    cyc(3);
    total++;
    if ({mode, time_run, ring, snoozing} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: got mode=%0d run=%b ring=%b snz=%b want 0 1 0 0",
               mode, time_run, ring, snoozing);
    end
    total++;
    if ({inc_th, inc_tm, inc_ah, inc_am, sec_clr} !== 5'b0) begin
      bad++;
      $display("FAIL reset_pulses: got %b want 00000",
               {inc_th, inc_tm, inc_ah, inc_am, sec_clr});
    end
    reset = 1'b0;
    cyc(6);
    total++;
    if (mode !== 3'd0 || n_clr != 0) begin
      bad++;
      $display("FAIL reset_held_key: got mode=%0d clr=%0d want 0 0", mode, n_clr);
    end
    key_mode = 1'b0;
    key_adv = 1'b0;
    cyc(3);
    exp_mode = 0;
  endtask

  task automatic test_mode_cycle();
    int clr0, inc0, exp_clr;
    bit exp_run;
    clr0 = n_clr;
    inc0 = n_th + n_tm + n_ah + n_am;
    exp_clr = 0;
    // Latency: mode must still be old two edges after the key rises.
    key_mode = 1'b1;
    cyc(2);
    total++;
    if (mode !== 3'(exp_mode)) begin
      bad++;
      $display("FAIL mode_latency_early: got %0d want %0d", mode, exp_mode);
    end
    cyc(1);
    total++;
    if (mode !== 3'((exp_mode + 1) % 5)) begin
      bad++;
      $display("FAIL mode_latency: got %0d want %0d", mode, (exp_mode + 1) % 5);
    end
    key_mode = 1'b0;
    cyc(4);
    exp_mode = (exp_mode + 1) % 5;
    for (int i = 1; i < 6; i++) begin
      if (i > 1) begin
        press_mode();
        exp_mode = (exp_mode + 1) % 5;
      end
      if (exp_mode == 3) exp_clr++;
      exp_run = !(exp_mode == 1 || exp_mode == 2);
      total++;
      if (mode !== 3'(exp_mode) || time_run !== exp_run) begin
        bad++;
        $display("FAIL mode_step%0d: got mode=%0d run=%b want %0d %b",
                 i, mode, time_run, exp_mode, exp_run);
      end
      total++;
      if (n_clr - clr0 != exp_clr) begin
        bad++;
        $display("FAIL sec_clr_step%0d: got %0d pulses want %0d", i, n_clr - clr0, exp_clr);
      end
    end
    total++;
    if (n_th + n_tm + n_ah + n_am != inc0) begin
      bad++;
      $display("FAIL mode_no_inc: got %0d want %0d", n_th + n_tm + n_ah + n_am, inc0);
    end
  endtask

  task automatic test_increments();
    int exp_n[4];
    int base[4];
    int got[4];
    base = '{n_th, n_tm, n_ah, n_am};
    exp_n = '{0, 0, 0, 0};
    for (int m = 1; m <= 4; m++) begin
      int presses;
      goto_mode(m);
      presses = (m == 4) ? 3 : $urandom_range(1, 4);
      for (int p = 0; p < presses; p++) press_adv();
      exp_n[m-1] += presses;
      got = '{n_th - base[0], n_tm - base[1], n_ah - base[2], n_am - base[3]};
      total++;
      if (got != exp_n) begin
        bad++;
        $display("FAIL inc_mode%0d: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", m,
                 got[0], got[1], got[2], got[3], exp_n[0], exp_n[1], exp_n[2], exp_n[3]);
      end
    end
    goto_mode(0);
    press_adv();
    press_adv();
    got = '{n_th - base[0], n_tm - base[1], n_ah - base[2], n_am - base[3]};
    total++;
    if (got != exp_n) begin
      bad++;
      $display("FAIL inc_run_none: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
               got[0], got[1], got[2], got[3], exp_n[0], exp_n[1], exp_n[2], exp_n[3]);
    end
  endtask

  task automatic test_ring_timeout();
    alarm_arm = 1'b1;
    trigger_ring("timeout");
    do_ticks(RING - 1);
    total++;
    if (ring !== 1'b1) begin
      bad++;
      $display("FAIL ring_before_timeout: got %b want 1", ring);
    end
    do_ticks(1);
    total++;
    if (ring !== 1'b0) begin
      bad++;
      $display("FAIL ring_timeout: got %b want 0", ring);
    end
    // Time is frozen on the matching minute: the level match must not retrigger.
    cyc(20);
    total++;
    if (ring !== 1'b0 || snoozing !== 1'b0) begin
      bad++;
      $display("FAIL ring_no_retrigger: got ring=%b snz=%b want 0 0", ring, snoozing);
    end
  endtask

  task automatic test_snooze();
    trigger_ring("snooze");
    do_ticks($urandom_range(1, RING - 2));
    press_adv();
    total++;
    if (snoozing !== 1'b1 || ring !== 1'b0) begin
      bad++;
      $display("FAIL snooze_enter: got snz=%b ring=%b want 1 0", snoozing, ring);
    end
    do_ticks(SNZ - 1);
    total++;
    if (snoozing !== 1'b1 || ring !== 1'b0) begin
      bad++;
      $display("FAIL snooze_before_end: got snz=%b ring=%b want 1 0", snoozing, ring);
    end
    do_ticks(1);
    total++;
    if (snoozing !== 1'b0 || ring !== 1'b1) begin
      bad++;
      $display("FAIL snooze_rering: got snz=%b ring=%b want 0 1", snoozing, ring);
    end
    do_ticks(RING - 1);
    total++;
    if (ring !== 1'b1) begin
      bad++;
      $display("FAIL rering_full: got %b want 1", ring);
    end
    do_ticks(1);
    total++;
    if (ring !== 1'b0) begin
      bad++;
      $display("FAIL rering_timeout: got %b want 0", ring);
    end
  endtask

  task automatic test_dismiss_disarm();
    trigger_ring("dismiss");
    do_ticks($urandom_range(0, 5));
    press_mode();
    total++;
    if (ring !== 1'b0 || snoozing !== 1'b0 || mode !== 3'(exp_mode)) begin
      bad++;
      $display("FAIL dismiss: got ring=%b snz=%b mode=%0d want 0 0 %0d",
               ring, snoozing, mode, exp_mode);
    end
    trigger_ring("disarm");
    press_adv();
    alarm_arm = 1'b0;
    cyc(1);
    total++;
    if (ring !== 1'b0 || snoozing !== 1'b0) begin
      bad++;
      $display("FAIL disarm: got ring=%b snz=%b want 0 0", ring, snoozing);
    end
    alarm_arm = 1'b1;
    cyc(2);
    trigger_ring("cancel");
    press_adv();
    press_mode();
    exp_mode = (exp_mode + 1) % 5;
    total++;
    if (snoozing !== 1'b0 || ring !== 1'b0 || mode !== 3'(exp_mode)) begin
      bad++;
      $display("FAIL snooze_cancel: got snz=%b ring=%b mode=%0d want 0 0 %0d",
               snoozing, ring, mode, exp_mode);
    end
    goto_mode(0);
  endtask

  task automatic test_reset_mid();
    int pulses0;
    trigger_ring("midrst");
    press_adv();
    sec = 8'd5;
    key_mode = 1'b1;
    key_adv = 1'b1;
    reset = 1'b1;
    cyc(1);
    total++;
    if ({mode, time_run, ring, snoozing} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL midrst_state: got mode=%0d run=%b ring=%b snz=%b want 0 1 0 0",
               mode, time_run, ring, snoozing);
    end
    cyc(1);
    reset = 1'b0;
    pulses0 = n_th + n_tm + n_ah + n_am + n_clr;
    cyc(6);
    total++;
    if (mode !== 3'd0 || snoozing !== 1'b0 || ring !== 1'b0 ||
        n_th + n_tm + n_ah + n_am + n_clr != pulses0) begin
      bad++;
      $display("FAIL midrst_release: got mode=%0d snz=%b ring=%b pulses=%0d want 0 0 0 0",
               mode, snoozing, ring, n_th + n_tm + n_ah + n_am + n_clr - pulses0);
    end
    key_mode = 1'b0;
    key_adv = 1'b0;
    cyc(3);
    exp_mode = 0;
    // Reset while in a set mode with the advance key held.
    goto_mode(2);
    key_adv = 1'b1;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    pulses0 = n_th + n_tm + n_ah + n_am + n_clr;
    cyc(6);
    total++;
    if (mode !== 3'd0 || time_run !== 1'b1 || n_th + n_tm + n_ah + n_am + n_clr != pulses0) begin
      bad++;
      $display("FAIL settm_rst: got mode=%0d run=%b pulses=%0d want 0 1 0",
               mode, time_run, n_th + n_tm + n_ah + n_am + n_clr - pulses0);
    end
    key_adv = 1'b0;
    cyc(3);
    exp_mode = 0;
  endtask

  initial begin
    cyc(1);
    test_reset();
    test_mode_cycle();
    test_increments();
    test_ring_timeout();
    test_snooze();
    test_dismiss_disarm();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
